mult_seq_ctrl: RTL and testbench

- Sequencing controller for the add-shift signed multiplier datapath: 9-bit A/X register, 8-bit B register and 9-bit add/sub unit.
- Turns the two user buttons, Execute and ClearA_loadB, into per-cycle enables:
  - clear-A/load-B
  - conditional add
  - final-cycle subtract
  - joint A/B shift
- Runs exactly one WIDTH-iteration multiply per Execute press, then waits for button release.

---
 rtl/mult_ctrl_pkg.sv | 15 +
 rtl/sync_2ff.sv | 21 ++
 rtl/mult_seq_ctrl.sv | 107 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the add-shift multiplier sequencer.
package mult_ctrl_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int ITER_W    = $clog2(DEF_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ADD,
    SHIFT,
    HOLD
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a raw asynchronous level; 2-cycle latency, no backpressure.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the add-shift signed multiplier: one WIDTH-iteration run per Execute press.
// Run takes 1 + 2*WIDTH cycles from CLEAR to Done; buttons act 2 cycles after sampling, no backpressure.
module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Execute,
  input  logic                     ClearA_loadB,
  input  logic                     M,
  output logic                     Clr_Ld,
  output logic                     ClearAX,
  output logic                     Add_en,
  output logic                     Sub_en,
  output logic                     Shift_en,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(WIDTH)-1:0] Iter
);

  localparam int            IW   = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  logic          execute_s;
  logic          clear_load_s;
  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] iter_nxt;

  sync_2ff u_sync_execute (
    .clk   (Clk),
    .rst_n (Reset),
    .d     (Execute),
    .q     (execute_s)
  );

  sync_2ff u_sync_clear_load (
    .clk   (Clk),
    .rst_n (Reset),
    .d     (ClearA_loadB),
    .q     (clear_load_s)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      Iter  <= '0;
    end else begin
      state <= state_nxt;
      Iter  <= iter_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    iter_nxt  = Iter;
    Clr_Ld    = 1'b0;
    ClearAX   = 1'b0;
    Add_en    = 1'b0;
    Sub_en    = 1'b0;
    Shift_en  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;

    case (state)
      IDLE: begin
        // Execute wins a tie with the load button; the load is dropped.
        Clr_Ld = clear_load_s & ~execute_s;
        if (execute_s) begin
          state_nxt = CLEAR;
          iter_nxt  = '0;
        end
      end
      CLEAR: begin
        ClearAX   = 1'b1;
        Busy      = 1'b1;
        state_nxt = ADD;
      end
      ADD: begin
        // The sign bit of the multiplier carries negative weight, hence subtract last.
        Busy = 1'b1;
        if (Iter == LAST) Sub_en = M;
        else              Add_en = M;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        Shift_en = 1'b1;
        Busy     = 1'b1;
        if (Iter == LAST) begin
          Done      = 1'b1;
          iter_nxt  = '0;
          state_nxt = HOLD;
        end else begin
          iter_nxt  = Iter + IW'(1);
          state_nxt = ADD;
        end
      end
      HOLD: begin
        if (!execute_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a small signed add-shift datapath model driving M.
module tb_mult_seq_ctrl;
  import mult_ctrl_pkg::*;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Execute;
  logic              ClearA_loadB;
  logic              M;
  logic              Clr_Ld, ClearAX, Add_en, Sub_en, Shift_en, Busy, Done;
  logic [ITER_W-1:0] Iter;

  int checks = 0;
  int errors = 0;

  logic [7:0] sw = 8'h00;
  logic [7:0] ma;
  logic [7:0] mb;
  logic       mx;
  logic       use_model = 1'b0;
  logic       m_tie = 1'b0;

  int cyc, n_clrax, n_shift, n_add, n_sub, n_busy, n_done, n_clrld;
  int n_overlap, n_misplaced, first_clrax, first_clrld, done_at, iter_at_done, iter_at_sub;

  mult_seq_ctrl #(.WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Execute      (Execute),
    .ClearA_loadB (ClearA_loadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .ClearAX      (ClearAX),
    .Add_en       (Add_en),
    .Sub_en       (Sub_en),
    .Shift_en     (Shift_en),
    .Busy         (Busy),
    .Done         (Done),
    .Iter         (Iter)
  );

  always #5 Clk = ~Clk;

  assign M = use_model ? mb[0] : m_tie;

  // X:A holds the 9-bit signed partial product; B shifts out multiplier bits into M.
  always @(posedge Clk) begin
    if (Clr_Ld) begin
      ma <= 8'h00; mx <= 1'b0; mb <= sw;
    end else if (ClearAX) begin
      ma <= 8'h00; mx <= 1'b0;
    end else if (Add_en) begin
      {mx, ma} <= {ma[7], ma} + {sw[7], sw};
    end else if (Sub_en) begin
      {mx, ma} <= {ma[7], ma} - {sw[7], sw};
    end else if (Shift_en) begin
      ma <= {mx, ma[7:1]};
      mb <= {ma[0], mb[7:1]};
    end
  end

  task automatic clear_acc();
    cyc = 0; n_clrax = 0; n_shift = 0; n_add = 0; n_sub = 0; n_busy = 0;
    n_done = 0; n_clrld = 0; n_overlap = 0; n_misplaced = 0;
    first_clrax = -1; first_clrld = -1; done_at = -1; iter_at_done = -1; iter_at_sub = -1;
  endtask

  task automatic step(input logic ex, input logic cla);
    @(negedge Clk);
    if (ClearAX) begin
      n_clrax++;
      if (first_clrax < 0) first_clrax = cyc;
    end
    if (Shift_en) begin
      n_shift++;
      if (first_clrax < 0 || ((cyc - first_clrax) % 2) != 0) n_misplaced++;
    end
    if (Add_en) n_add++;
    if (Sub_en) begin
      n_sub++;
      iter_at_sub = int'(Iter);
    end
    if (Add_en && Sub_en) n_overlap++;
    if (Busy) n_busy++;
    if (Clr_Ld) begin
      n_clrld++;
      if (first_clrld < 0) first_clrld = cyc;
    end
    if (Done) begin
      n_done++;
      done_at = cyc;
      iter_at_done = int'(Iter);
    end
    cyc++;
    Execute = ex;
    ClearA_loadB = cla;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Execute = 1'b0; ClearA_loadB = 1'b0;
    #3;
    checks++;
    if ({Clr_Ld, ClearAX, Add_en, Sub_en, Shift_en, Busy, Done, Iter} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero",
               {Clr_Ld, ClearAX, Add_en, Sub_en, Shift_en, Busy, Done, Iter});
    end
    Execute = 1'b1; ClearA_loadB = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if ({Clr_Ld, ClearAX, Add_en, Sub_en, Shift_en, Busy, Done, Iter} !== '0) begin
      errors++;
      $display("FAIL reset_held: got %b want all zero",
               {Clr_Ld, ClearAX, Add_en, Sub_en, Shift_en, Busy, Done, Iter});
    end
    Execute = 1'b0; ClearA_loadB = 1'b0;
    Reset = 1'b1;
    clear_acc();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    checks++;
    if (n_busy != 0 || n_clrax != 0 || n_clrld != 0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%0d clrax=%0d clrld=%0d want 0 0 0",
               n_busy, n_clrax, n_clrld);
    end
  endtask

  task automatic test_m0_pulse();
    use_model = 1'b0; m_tie = 1'b0;
    clear_acc();
    for (int i = 0; i < 30; i++) step(i < 3, 1'b0);
    checks++;
    if (first_clrax != 3 || n_clrax != 1) begin
      errors++;
      $display("FAIL m0_clear: first=%0d count=%0d want 3 1", first_clrax, n_clrax);
    end
    checks++;
    if (n_shift != 8 || n_misplaced != 0) begin
      errors++;
      $display("FAIL m0_shifts: count=%0d misplaced=%0d want 8 0", n_shift, n_misplaced);
    end
    checks++;
    if (n_add != 0 || n_sub != 0) begin
      errors++;
      $display("FAIL m0_addsub: add=%0d sub=%0d want 0 0", n_add, n_sub);
    end
    checks++;
    if (n_done != 1 || done_at - first_clrax != 16 || iter_at_done != 7) begin
      errors++;
      $display("FAIL m0_done: count=%0d offset=%0d iter=%0d want 1 16 7",
               n_done, done_at - first_clrax, iter_at_done);
    end
    checks++;
    if (n_busy != 17) begin
      errors++;
      $display("FAIL m0_busy: got %0d cycles want 17", n_busy);
    end
    checks++;
    if (Busy !== 1'b0 || Iter !== '0) begin
      errors++;
      $display("FAIL m0_end_state: busy=%b iter=%0d want 0 0", Busy, Iter);
    end
  endtask

  task automatic test_clear_load();
    sw = 8'hFF;
    clear_acc();
    for (int i = 0; i < 10; i++) step(1'b0, i < 4);
    checks++;
    if (first_clrld != 2 || n_clrld != 4) begin
      errors++;
      $display("FAIL clear_load_window: first=%0d count=%0d want 2 4", first_clrld, n_clrld);
    end
    checks++;
    if (n_clrax != 0 || n_busy != 0 || mb !== 8'hFF) begin
      errors++;
      $display("FAIL clear_load_effect: clrax=%0d busy=%0d b=%h want 0 0 ff", n_clrax, n_busy, mb);
    end
  endtask

  task automatic test_m1_multiply();
    sw = 8'h05;
    use_model = 1'b1;
    clear_acc();
    for (int i = 0; i < 30; i++) step(i < 2, 1'b0);
    checks++;
    if (n_add != 7 || n_sub != 1 || iter_at_sub != 7) begin
      errors++;
      $display("FAIL m1_pulses: add=%0d sub=%0d sub_iter=%0d want 7 1 7", n_add, n_sub, iter_at_sub);
    end
    checks++;
    if (n_overlap != 0) begin
      errors++;
      $display("FAIL m1_overlap: got %0d want 0", n_overlap);
    end
    checks++;
    if ({ma, mb} !== 16'hFFFB) begin
      errors++;
      $display("FAIL m1_product: got %h want fffb", {ma, mb});
    end
    use_model = 1'b0;
  endtask

  task automatic test_execute_held();
    clear_acc();
    for (int i = 0; i < 70; i++) step(i < 60, (i >= 40) && (i < 66));
    checks++;
    if (n_clrax != 1 || n_done != 1 || n_busy != 17) begin
      errors++;
      $display("FAIL held_single_run: clrax=%0d done=%0d busy=%0d want 1 1 17",
               n_clrax, n_done, n_busy);
    end
    checks++;
    if (first_clrld != 63 || n_clrld != 5) begin
      errors++;
      $display("FAIL held_idle_return: first_clrld=%0d count=%0d want 63 5", first_clrld, n_clrld);
    end
  endtask

  task automatic test_back_to_back();
    clear_acc();
    for (int i = 0; i < 30; i++) step(i < 3, 1'b0);
    checks++;
    if (first_clrax != 3 || n_done != 1 || n_busy != 17) begin
      errors++;
      $display("FAIL second_run: first=%0d done=%0d busy=%0d want 3 1 17",
               first_clrax, n_done, n_busy);
    end
  endtask

  task automatic test_clear_midrun();
    clear_acc();
    for (int i = 0; i < 30; i++) step(i < 3, (i >= 10) && (i < 13));
    checks++;
    if (n_clrld != 0 || n_done != 1 || n_busy != 17) begin
      errors++;
      $display("FAIL clear_midrun: clrld=%0d done=%0d busy=%0d want 0 1 17", n_clrld, n_done, n_busy);
    end
  endtask

  task automatic test_exec_priority();
    clear_acc();
    for (int i = 0; i < 30; i++) step(i < 3, i < 3);
    checks++;
    if (n_clrld != 0 || first_clrax != 3 || n_done != 1) begin
      errors++;
      $display("FAIL exec_priority: clrld=%0d first=%0d done=%0d want 0 3 1",
               n_clrld, first_clrax, n_done);
    end
  endtask

  task automatic test_reset_midrun();
    logic found = 1'b0;
    clear_acc();
    for (int i = 0; i < 40 && !found; i++) begin
      step(i < 3, 1'b0);
      if (Shift_en && Iter == ITER_W'(4)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_midrun_reach: shift at iter 4 seen=%b want 1", found);
    end else begin
      #1 Reset = 1'b0;
      #1;
      checks++;
      if ({Clr_Ld, ClearAX, Add_en, Sub_en, Shift_en, Busy, Done, Iter} !== '0) begin
        errors++;
        $display("FAIL reset_midrun_async: got %b want all zero",
                 {Clr_Ld, ClearAX, Add_en, Sub_en, Shift_en, Busy, Done, Iter});
      end
      @(posedge Clk);
      #1;
      checks++;
      if ({Busy, Shift_en, Iter} !== '0) begin
        errors++;
        $display("FAIL reset_midrun_hold: got %b want all zero", {Busy, Shift_en, Iter});
      end
      @(negedge Clk);
      Reset = 1'b1;
    end
    clear_acc();
    for (int i = 0; i < 30; i++) step(i < 3, 1'b0);
    checks++;
    if (first_clrax != 3 || n_done != 1 || n_busy != 17 || done_at - first_clrax != 16) begin
      errors++;
      $display("FAIL reset_rerun: first=%0d done=%0d busy=%0d offset=%0d want 3 1 17 16",
               first_clrax, n_done, n_busy, done_at - first_clrax);
    end
  endtask

  initial begin
    test_reset();
    test_m0_pulse();
    test_clear_load();
    test_m1_multiply();
    test_execute_held();
    test_back_to_back();
    test_clear_midrun();
    test_exec_priority();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
